// File: rtl/io_pkg.sv
// Shared constants for the memory-mapped CPU I/O ports.
package io_pkg;
  localparam int IO_PORT_W         = 32;
  localparam int DB_CYCLES_DEFAULT = 50000;
  localparam int DB_CYCLES_SIM     = 4;
  localparam int EDGE_CNT_W        = 16;
endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-flop synchroniser, debounce counter and stable flop.
// flip_o marks the cycle in which stable_o is about to update.
module sw_debounce_bit #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic sw_i,
  output logic stable_o,
  output logic flip_o
);
  logic             s1_q, s2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flip;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    flip     = 1'b0;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
      stable_d = s2_q;
      cnt_d    = '0;
      flip     = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= sw_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign flip_o   = flip;
endmodule

// File: rtl/in_port_debounce.sv
// Debounced switch input port: zero-extended stable word, sticky changed flag,
// change pulse. IN_PORT_EDGE_CNT_EN adds a rising-edge counter on in_port[31:16].
module in_port_debounce
  import io_pkg::*;
#(
  parameter int N_SW      = 5,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [N_SW-1:0]      sw,
  input  logic                 rd_ack,
  output logic [IO_PORT_W-1:0] in_port,
  output logic                 changed,
  output logic                 change_pulse
);
  logic [N_SW-1:0] stable, flip;
  logic            any_flip;
  logic            changed_q, pulse_q;
  logic [IO_PORT_W-1:0] word;

  for (genvar i = 0; i < N_SW; i++) begin : g_bit
    sw_debounce_bit #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_bit (
      .clk     (clk),
      .resetn  (resetn),
      .sw_i    (sw[i]),
      .stable_o(stable[i]),
      .flip_o  (flip[i])
    );
  end

  assign any_flip = |flip;

  // Set beats rd_ack so an update landing on the read cycle is not lost.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      changed_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      pulse_q <= any_flip;
      if (any_flip)    changed_q <= 1'b1;
      else if (rd_ack) changed_q <= 1'b0;
    end
  end

`ifdef IN_PORT_EDGE_CNT_EN
  logic [EDGE_CNT_W-1:0] edge_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                    edge_cnt_q <= '0;
    else if (flip[0] && !stable[0]) edge_cnt_q <= edge_cnt_q + 1'b1;
  end
`endif

  always_comb begin
    word             = '0;
    word[N_SW-1:0]   = stable;
`ifdef IN_PORT_EDGE_CNT_EN
    word[IO_PORT_W-1 -: EDGE_CNT_W] = edge_cnt_q;
`endif
  end

  assign in_port      = word;
  assign changed      = changed_q;
  assign change_pulse = pulse_q;
endmodule

// File: tb/tb_in_port_debounce.sv
// Self-checking bench for in_port_debounce (DB_CYCLES=4, N_SW=5).
module tb_in_port_debounce;
  import io_pkg::*;
  localparam int N_SW = 5;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            rd_ack = 1'b0;
  logic [N_SW-1:0] sw = '0;
  logic [31:0]     in_port;
  logic            changed, change_pulse;

  always #5 clk = ~clk;

  in_port_debounce #(.N_SW(N_SW), .DB_CYCLES(DB_CYCLES_SIM), .CNT_W(16)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .sw          (sw),
    .rd_ack      (rd_ack),
    .in_port     (in_port),
    .changed     (changed),
    .change_pulse(change_pulse)
  );

  // One row = hold sw for n edges; rd_ack only on the last edge.
  // Intermediate edges expect the previous row's state and no pulse.
  typedef struct {
    logic [N_SW-1:0] sw;
    logic            ack;
    int              n;
    logic [15:0]     lo;
    logic            chg;
    logic            pulse;
    string           name;
  } vec_t;

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic        chg;
    logic        pulse;
  } exp_t;

  exp_t        sb[$];
  int          passed = 0;
  int          total  = 0;
  logic [15:0] prev_lo = '0;
  logic        prev_chg = 1'b0;
  logic [15:0] exp_ec = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  function automatic logic [15:0] hi_exp();
`ifdef IN_PORT_EDGE_CNT_EN
    return exp_ec;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic tick(input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({nm, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({nm, " in_port[15:0]"},  {16'h0, in_port[15:0]},  {16'h0, e.lo});
      chk({nm, " in_port[31:16]"}, {16'h0, in_port[31:16]}, {16'h0, e.hi});
      chk({nm, " changed"},        {31'h0, changed},        {31'h0, e.chg});
      chk({nm, " change_pulse"},   {31'h0, change_pulse},   {31'h0, e.pulse});
    end
  endtask

  task automatic run_row(input vec_t v);
    exp_t e;
    for (int c = 0; c < v.n; c++) begin
      sw     = v.sw;
      rd_ack = (c == v.n - 1) ? v.ack : 1'b0;
      if (c == v.n - 1) begin
        if (v.lo[0] && !prev_lo[0]) exp_ec = exp_ec + 16'd1;
        e.lo = v.lo; e.chg = v.chg; e.pulse = v.pulse;
      end else begin
        e.lo = prev_lo; e.chg = prev_chg; e.pulse = 1'b0;
      end
      e.hi = hi_exp();
      sb.push_back(e);
      tick(v.name);
    end
    rd_ack   = 1'b0;
    prev_lo  = v.lo;
    prev_chg = v.chg;
  endtask

  vec_t tbl[$];

  initial begin
    tbl.push_back('{5'b10110, 1'b0, 6, 16'h0016, 1'b1, 1'b1, "first update"});
    tbl.push_back('{5'b10110, 1'b0, 1, 16'h0016, 1'b1, 1'b0, "pulse drops"});
    tbl.push_back('{5'b11110, 1'b0, 3, 16'h0016, 1'b1, 1'b0, "glitch high"});
    tbl.push_back('{5'b10110, 1'b0, 3, 16'h0016, 1'b1, 1'b0, "glitch gone"});
    tbl.push_back('{5'b10110, 1'b1, 1, 16'h0016, 1'b0, 1'b0, "rd_ack clears"});
    tbl.push_back('{5'b10110, 1'b0, 1, 16'h0016, 1'b0, 1'b0, "idle"});
    tbl.push_back('{5'b10111, 1'b1, 6, 16'h0017, 1'b1, 1'b1, "set beats ack"});
    tbl.push_back('{5'b10111, 1'b0, 1, 16'h0017, 1'b1, 1'b0, "after set"});
    tbl.push_back('{5'b00110, 1'b0, 6, 16'h0006, 1'b1, 1'b1, "two bits flip"});
    tbl.push_back('{5'b00110, 1'b0, 1, 16'h0006, 1'b1, 1'b0, "single pulse"});

    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_port", in_port, 32'h0);
    chk("reset changed", {31'h0, changed}, 32'h0);
    chk("reset change_pulse", {31'h0, change_pulse}, 32'h0);
    resetn = 1'b1;

    foreach (tbl[k]) begin
      run_row(tbl[k]);
      if (k == 2) chk("glitch cnt[3] mid", 32'(dut.g_bit[3].u_bit.cnt_q), 32'd1);
      if (k == 3) chk("glitch cnt[3] cleared", 32'(dut.g_bit[3].u_bit.cnt_q), 32'd0);
    end

    // Async reset with a count in flight.
    run_row('{5'b00001, 1'b0, 4, 16'h0006, 1'b1, 1'b0, "pre-reset count"});
    chk("cnt[0] before reset", 32'(dut.g_bit[0].u_bit.cnt_q), 32'd2);
    #2 resetn = 1'b0;
    #1;
    chk("async reset in_port", in_port, 32'h0);
    chk("async reset changed", {31'h0, changed}, 32'h0);
    chk("async reset change_pulse", {31'h0, change_pulse}, 32'h0);
    chk("async reset cnt[0]", 32'(dut.g_bit[0].u_bit.cnt_q), 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    prev_lo = '0; prev_chg = 1'b0; exp_ec = '0;
    run_row('{5'b00001, 1'b0, 6, 16'h0001, 1'b1, 1'b1, "post-reset update"});
    run_row('{5'b00001, 1'b0, 1, 16'h0001, 1'b1, 1'b0, "post-reset hold"});

`ifdef IN_PORT_EDGE_CNT_EN
    run_row('{5'b00000, 1'b0, 6, 16'h0000, 1'b1, 1'b1, "ec fall 1"});
    run_row('{5'b00001, 1'b0, 6, 16'h0001, 1'b1, 1'b1, "ec rise 2"});
    run_row('{5'b00000, 1'b0, 6, 16'h0000, 1'b1, 1'b1, "ec fall 2"});
    run_row('{5'b00001, 1'b0, 6, 16'h0001, 1'b1, 1'b1, "ec rise 3"});
    chk("edge count three", {16'h0, in_port[31:16]}, 32'h0003);
    run_row('{5'b00000, 1'b0, 6, 16'h0000, 1'b1, 1'b1, "ec fall 3"});
    force dut.edge_cnt_q = 16'hFFFF;
    #1 release dut.edge_cnt_q;
    exp_ec = 16'hFFFF;
    run_row('{5'b00001, 1'b0, 6, 16'h0001, 1'b1, 1'b1, "ec wrap"});
    chk("edge count wrap", {16'h0, in_port[31:16]}, 32'h0000);
`endif

    chk("scoreboard drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
